// File: rtl/rank_cmd_scheduler.sv
// Rank command scheduler: queues upstream requests in a small FIFO and issues
// them one at a time to a 4-rank package. A command is only issued once the
// selected rank reports idle (ba_cmd_pm == 0). The scheduler then waits for the
// read data or write completion, and aborts the wait after HOLD_TIMEOUT cycles.
module rank_cmd_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         power_on_rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_rank,
  input  logic [0:0]   req_is_read,
  input  logic [31:0]  req_cmd,
  input  logic [127:0] req_wdata,
  output logic [33:0]  command,
  output logic [0:0]   valid,
  output logic [127:0] write_data,
  input  logic [3:0]   ba_cmd_pm,
  input  logic [127:0] read_data,
  input  logic [0:0]   read_data_valid,
  output logic [0:0]   rsp_valid,
  output logic [1:0]   rsp_rank,
  output logic [127:0] rsp_data,
  output logic [0:0]   err_timeout,
  output logic [0:0]   busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W  = $clog2(HOLD_TIMEOUT + 1);
  localparam int ENTRY_W = 2 + 1 + 32 + 128;

  typedef enum logic [1:0] {IDLE, SEL, ISSUE, HOLD} state_t;

  state_t state_reg, state_next;

  // Queue storage; entry layout is {rank, is_read, cmd, wdata}
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full, empty, push, pop;

  logic [1:0]   head_rank;
  logic         head_is_read;
  logic [31:0]  head_cmd;
  logic [127:0] head_wdata;

  // Context of the single outstanding command
  logic [1:0]        cur_rank_reg;
  logic              cur_is_read_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_exit, hold_expire;

  logic         rsp_valid_reg, err_reg;
  logic [1:0]   rsp_rank_reg;
  logic [127:0] rsp_data_reg;

  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty = (count_reg == '0);
  // Ready comes only from the registered count, so a same-cycle pop never frees a slot early
  assign req_ready = !full && !power_on_rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state_reg == ISSUE);

  assign {head_rank, head_is_read, head_cmd, head_wdata} = fifo_mem[rd_ptr_reg];

  // Reads complete on returned data; writes complete once the rank reports idle again
  assign hold_exit   = cur_is_read_reg ? read_data_valid[0] : (ba_cmd_pm == 4'b0000);
  assign hold_expire = (hold_cnt_reg == HOLD_W'(HOLD_TIMEOUT - 1));

  // Store accepted requests at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_rank, req_is_read, req_cmd, req_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (power_on_rst) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty) state_next = SEL;
      SEL:     if (ba_cmd_pm == 4'b0000) state_next = ISSUE;
      ISSUE:   state_next = HOLD;
      HOLD:    if (hold_exit || hold_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs toward the rank package
  always_comb begin
    command    = {cur_rank_reg, 32'h0};
    valid      = 1'b0;
    write_data = '0;
    case (state_reg)
      SEL:   command = {head_rank, 32'h0};
      ISSUE: begin
        command    = {head_rank, head_cmd};
        valid      = 1'b1;
        write_data = head_is_read ? 128'h0 : head_wdata;
      end
      default: ;
    endcase
  end

  // Outstanding-command context, HOLD timer, read response and sticky timeout flag
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      cur_rank_reg    <= '0;
      cur_is_read_reg <= 1'b0;
      hold_cnt_reg    <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rank_reg    <= '0;
      rsp_data_reg    <= '0;
      err_reg         <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (state_reg == ISSUE) begin
        cur_rank_reg    <= head_rank;
        cur_is_read_reg <= head_is_read;
        hold_cnt_reg    <= '0;
      end
      if (state_reg == HOLD) begin
        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        if (cur_is_read_reg && read_data_valid[0]) begin
          rsp_valid_reg <= 1'b1;
          rsp_rank_reg  <= cur_rank_reg;
          rsp_data_reg  <= read_data;
        end else if (!hold_exit && hold_expire) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rank    = rsp_rank_reg;
  assign rsp_data    = rsp_data_reg;
  assign err_timeout = err_reg;
  assign busy        = (state_reg != IDLE) || !empty;

endmodule

// File: doc/rank_cmd_scheduler.md
RANK_CMD_SCHEDULER -- requirements
Module: rank_cmd_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request queue entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 256, meaning max cycles in HOLD before abort.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port power_on_rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports req_valid/req_ready, input/output, 1 each, upstream request handshake.
REQ-006 SHALL have ports req_rank [1:0], req_is_read [0:0], req_cmd [31:0], req_wdata [127:0], all inputs, forming the request payload.
REQ-007 SHALL have ports command [33:0], valid [0:0], write_data [127:0], all outputs, driving the 4-rank package; command[33:32] = rank select, command[31:0] = rank command.
REQ-008 SHALL have inputs ba_cmd_pm [3:0], read_data [127:0] and read_data_valid [0:0], returned by the package for the currently selected rank.
REQ-009 SHALL have outputs rsp_valid [0:0], rsp_rank [1:0], rsp_data [127:0] (read response), err_timeout [0:0] (sticky) and busy [0:0].

Function
REQ-010 SHALL queue requests in a FIFO_DEPTH FIFO of {rank, is_read, cmd, wdata}; push when req_valid && req_ready.
REQ-011 SHALL drive req_ready = !full, from the registered count; push while full is never accepted, even if a pop occurs in the same cycle.
REQ-012 SHALL support simultaneous push and pop when not full; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-013 SHALL implement FSM IDLE, SEL, ISSUE, HOLD.
REQ-014 IDLE: if FIFO non-empty -> SEL next cycle; else stay; command[33:32] holds last rank, command[31:0]=0, valid=0.
REQ-015 SEL: command[33:32]=head rank, command[31:0]=0, valid=0; if ba_cmd_pm==4'b0000 sampled -> ISSUE, else stay SEL (no limit).
REQ-016 ISSUE: exactly one cycle with valid=1, command={head rank, head cmd}, write_data=head wdata (0 for reads); pop head; -> HOLD.
REQ-017 HOLD: command[33:32] stays at issued rank, command[31:0]=0, valid=0, write_data=0.
REQ-018 HOLD, read: on read_data_valid=1 capture read_data; next cycle rsp_valid=1 for one cycle, rsp_rank=issued rank, rsp_data=captured data; -> IDLE.
REQ-019 HOLD, write: exit to IDLE on the first cycle, at least one cycle after ISSUE, in which ba_cmd_pm==4'b0000; read_data_valid ignored.
REQ-020 HOLD counter SHALL count cycles from entry; when it reaches HOLD_TIMEOUT with no exit condition -> set err_timeout=1, no rsp, -> IDLE.
REQ-021 err_timeout SHALL clear only on reset.
REQ-022 Minimum request-to-valid latency SHALL be 3 cycles from an accepting push into an empty FIFO in IDLE (push edge, SEL, ISSUE).
REQ-023 busy SHALL be 1 whenever state != IDLE or FIFO non-empty.
REQ-024 Commands SHALL issue strictly in FIFO order, with only one outstanding command at a time.

Reset
REQ-025 power_on_rst=1 at a clock edge SHALL empty the FIFO, force IDLE and clear the HOLD counter.
REQ-026 Outputs in reset SHALL be: req_ready=0 while asserted, then 1 afterwards; command=0; valid=0; write_data=0; rsp_valid=0; rsp_rank=0; rsp_data=0; err_timeout=0; busy=0.
REQ-027 Reset during ISSUE or HOLD SHALL abandon the command with no rsp; the pending entry is lost.

Verification
REQ-028 Read to rank 2: push rank 2, read, cmd 0x1234_0000 with ba_cmd_pm=0 -> valid pulse 3 cycles later with command=0x2_1234_0000; read_data_valid after 10 cycles with data 0xA5..A5 -> rsp_valid one cycle, rsp_rank=2, rsp_data=0xA5..A5.
REQ-029 Fill: push 5 back-to-back with ba_cmd_pm held 4'b0001 -> 4 accepted, req_ready=0 on the 5th, no valid issued; release ba_cmd_pm=0 -> 4 issues in order.
REQ-030 Write to rank 1 with wdata 0xDEAD..BEEF -> write_data equals it only in the valid cycle; ba_cmd_pm busy 3 cycles then 0 -> IDLE.
REQ-031 Read with no read_data_valid -> err_timeout=1 after 256 HOLD cycles; next queued request still issues.
REQ-032 Reset asserted in HOLD -> all outputs at reset values next cycle; no rsp_valid afterwards.
REQ-033 Simultaneous push/pop at count 3 -> count stays 3; wrap verified over 20 requests.
